multicycle_ctrl: RTL and testbench

//   Multi-cycle control FSM for the RV32I core. Sequences FETCH/DECODE/EXEC/MEM/WB around the

---
 rtl/multicycle_ctrl_pkg.sv | 64 ++++++
 rtl/multicycle_ctrl_watchdog.sv | 30 +++
 rtl/multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: opcodes, states, datapath selects,
// trap causes and the opcode classifier used in DECODE.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;
  typedef enum logic [2:0] {ClsR, ClsImm, ClsLui, ClsLoad, ClsStore, ClsBranch, ClsJal} cls_e;

  localparam logic [1:0] AluAdd   = 2'd0;
  localparam logic [1:0] AluSub   = 2'd1;
  localparam logic [1:0] AluFunct = 2'd2;
  localparam logic [1:0] AluPassB = 2'd3;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcBranch = 2'd1;
  localparam logic [1:0] PcJal    = 2'd2;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbLoad = 2'd1;
  localparam logic [1:0] WbPc4  = 2'd2;

  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseIllegal = 2'd1;
  localparam logic [1:0] CauseHalt    = 2'd2;
  localparam logic [1:0] CauseTimeout = 2'd3;

  typedef struct packed {
    logic legal;
    logic halt;
    cls_e cls;
  } dec_t;

  function automatic dec_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
    dec_t d;
    d.legal = 1'b1;
    d.halt  = 1'b0;
    d.cls   = ClsR;
    case (opcode)
      OpR:      d.cls = ClsR;
      OpImm:    d.cls = ClsImm;
      OpLui:    d.cls = ClsLui;
      OpLoad:   d.cls = ClsLoad;
      OpStore:  d.cls = ClsStore;
      OpBranch: d.cls = ClsBranch;
      OpJal:    d.cls = ClsJal;
      OpSystem: begin
        // Only ECALL/EBREAK (funct3=0) halt cleanly; CSR ops are unsupported.
        d.legal = 1'b0;
        d.halt  = (funct3 == 3'd0);
      end
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_watchdog.sv
// Bus watchdog: counts unacked request cycles; expired flags the last permitted wait cycle.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (count_en) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // High during the TIMEOUT_CYCLES-th consecutive unacked request cycle.
  assign expired = count_en && (cnt_q == Limit);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory handshakes,
// datapath write-enable pulses, retired counter and sticky trap.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             br_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src_b,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q;
  cls_e             cls_q;
  logic [1:0]       cause_q;
  logic             run_q;
  logic [CNT_W-1:0] retired_q;

  dec_t dec;
  logic in_bus, bus_ack, wd_expired, retire;

  assign dec     = classify(opcode, funct3);
  // run_q holds off the first fetch until one edge after reset release.
  assign in_bus  = ((state_q == StFetch) && run_q) || (state_q == StMem);
  assign bus_ack = (state_q == StFetch) ? imem_ack : dmem_ack;
  assign retire  = ((state_q == StExec) && (cls_q == ClsBranch)) ||
                   ((state_q == StMem) && dmem_ack && (cls_q == ClsStore)) ||
                   (state_q == StWb);

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_bus || bus_ack),
    .count_en(in_bus && !bus_ack),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      cause_q   <= CauseNone;
      run_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      unique case (state_q)
        StFetch: begin
          if (run_q && imem_ack) begin
            state_q <= StDecode;
          end else if (wd_expired) begin
            state_q <= StTrap;
            cause_q <= CauseTimeout;
          end
        end
        StDecode: begin
          if (dec.halt) begin
            state_q <= StTrap;
            cause_q <= CauseHalt;
          end else if (!dec.legal) begin
            state_q <= StTrap;
            cause_q <= CauseIllegal;
          end else begin
            cls_q   <= dec.cls;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cls_q == ClsLoad || cls_q == ClsStore) state_q <= StMem;
          else if (cls_q == ClsBranch)               state_q <= StFetch;
          else                                       state_q <= StWb;
        end
        StMem: begin
          if (dmem_ack) begin
            state_q <= (cls_q == ClsStore) ? StFetch : StWb;
          end else if (wd_expired) begin
            state_q <= StTrap;
            cause_q <= CauseTimeout;
          end
        end
        StWb:    state_q <= StFetch;
        StTrap:  state_q <= StTrap;
        default: state_q <= StTrap;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PcPlus4;
    alu_op    = AluAdd;
    alu_src_b = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WbAlu;
    unique case (state_q)
      StFetch: begin
        imem_req = run_q;
        ir_we    = run_q && imem_ack;
      end
      StExec: begin
        unique case (cls_q)
          ClsR:      alu_op = AluFunct;
          ClsImm:    begin alu_op = AluFunct; alu_src_b = 1'b1; end
          ClsLui:    begin alu_op = AluPassB; alu_src_b = 1'b1; end
          ClsLoad,
          ClsStore:  begin alu_op = AluAdd;   alu_src_b = 1'b1; end
          ClsBranch: begin
            alu_op = AluSub;
            pc_we  = 1'b1;
            pc_src = br_taken ? PcBranch : PcPlus4;
          end
          ClsJal:    begin pc_we = 1'b1; pc_src = PcJal; end
          default:   alu_op = AluAdd;
        endcase
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == ClsStore);
        pc_we    = (cls_q == ClsStore) && dmem_ack;
      end
      StWb: begin
        rf_we  = 1'b1;
        wb_sel = (cls_q == ClsLoad) ? WbLoad : (cls_q == ClsJal) ? WbPc4 : WbAlu;
        // JAL already redirected the PC in EXEC.
        pc_we  = (cls_q != ClsJal);
      end
      default: ;
    endcase
  end

  assign trap       = (state_q == StTrap);
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized instruction stream against an instruction-level expectation model.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'h00;
  logic [2:0] funct3 = 3'd0;
  logic       br_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_b, rf_we, trap;
  logic [1:0] pc_src, alu_op, wb_sel, trap_cause;
  logic [3:0] retired;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_ret = 4'd0;

  typedef enum int {KR, KI, KLui, KLd, KSt, KBr, KJal} kind_e;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .rf_we(rf_we), .wb_sel(wb_sel), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_op, alu_src_b, rf_we,
                wb_sel, trap, trap_cause};

  function automatic logic [15:0] ev(input logic ireq, dreq, dwe, ir, pcw,
                                     input logic [1:0] pcs, alu, input logic srcb, rfw,
                                     input logic [1:0] wbs, input logic tr,
                                     input logic [1:0] cause);
    return {ireq, dreq, dwe, ir, pcw, pcs, alu, srcb, rfw, wbs, tr, cause};
  endfunction

  localparam logic [15:0] Zero = 16'h0000;

  task automatic chk(input string tag, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
    checks++;
    assert (retired === exp_ret) else begin
      errors++;
      $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, exp_ret);
    end
  endtask

  // Check at the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [15:0] exp);
    #4;
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk("rst_async", Zero);
    exp_ret = 4'd0;
    chk_ret("rst_retired");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    chk("rst_release_idle", Zero);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] op_of(input kind_e k);
    case (k)
      KR:      return 7'b0110011;
      KI:      return 7'b0010011;
      KLui:    return 7'b0110111;
      KLd:     return 7'b0000011;
      KSt:     return 7'b0100011;
      KBr:     return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input int fw);
    for (int i = 0; i < fw; i++) begin
      imem_ack = 1'b0;
      opcode = 7'($urandom);
      cyc("fetch_wait", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    imem_ack = 1'b1;
    opcode = op;
    funct3 = f3;
    cyc("fetch_ack", ev(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    imem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
  endtask

  task automatic run_instr(input kind_e k, input int fw, input int mw, input logic br);
    logic st;
    st = (k == KSt);
    fetch(op_of(k), 3'($urandom), fw);
    cyc("decode", Zero);
    opcode = 7'($urandom);
    br_taken = br;
    case (k)
      KR:    cyc("exec_r",   ev(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
      KI:    cyc("exec_i",   ev(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
      KLui:  cyc("exec_lui", ev(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0));
      KLd,
      KSt:   cyc("exec_mem", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      KBr:   cyc("exec_br",  ev(0, 0, 0, 0, 1, br ? 2'd1 : 2'd0, 1, 0, 0, 0, 0, 0));
      default: cyc("exec_jal", ev(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
    endcase
    if (k == KLd || k == KSt) begin
      for (int i = 0; i < mw; i++) begin
        dmem_ack = 1'b0;
        cyc("mem_wait", ev(0, 1, st, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      dmem_ack = 1'b1;
      cyc("mem_ack", ev(0, 1, st, 0, st, 0, 0, 0, 0, 0, 0, 0));
      dmem_ack = 1'b0;
    end
    if (k != KBr && k != KSt) begin
      imem_ack = 1'($urandom);
      cyc("wb", ev(0, 0, 0, 0, k != KJal, 0, 0, 0, 1,
                   (k == KLd) ? 2'd1 : (k == KJal) ? 2'd2 : 2'd0, 0, 0));
    end
    exp_ret = exp_ret + 4'd1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk_ret("retire");
  endtask

  task automatic expect_trap(input logic [6:0] op, input logic [2:0] f3,
                             input logic [1:0] cause, input int n);
    fetch(op, f3, 0);
    cyc("decode_trap", Zero);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom);
      dmem_ack = 1'($urandom);
      cyc("trap_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, cause));
    end
    chk_ret("trap_retired_frozen");
  endtask

  initial begin
    apply_reset();

    // Directed instructions.
    run_instr(KI, 0, 0, 0);
    run_instr(KR, 3, 0, 0);
    run_instr(KLd, 0, 2, 0);
    run_instr(KSt, 1, 0, 0);
    run_instr(KBr, 0, 0, 1);
    run_instr(KBr, 0, 0, 0);
    run_instr(KJal, 0, 0, 0);
    run_instr(KLui, 2, 0, 0);

    // Random stream; long enough to wrap the 4-bit retired counter.
    for (int n = 0; n < 40; n++) begin
      run_instr(kind_e'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), 1'($urandom));
    end

    expect_trap(7'h7F, 3'd0, 2'd1, 50);
    apply_reset();
    expect_trap(7'b1110011, 3'd0, 2'd2, 10);
    apply_reset();
    expect_trap(7'b1110011, 3'd1, 2'd1, 5);
    apply_reset();

    // Fetch timeout: TO unacked request cycles, then trap.
    for (int i = 0; i < TO; i++) begin
      imem_ack = 1'b0;
      cyc("to_wait", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    dmem_ack = 1'b1;
    cyc("to_trap", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
    dmem_ack = 1'b0;
    apply_reset();

    // Ack on the last allowed cycle wins.
    run_instr(KI, TO - 1, 0, 0);
    run_instr(KSt, 0, TO - 1, 0);

    // Reset in the middle of a load's MEM wait.
    fetch(op_of(KLd), 3'd2, 0);
    cyc("mid_decode", Zero);
    cyc("mid_exec", ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    dmem_ack = 1'b0;
    #2;
    chk("mid_mem", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply_reset();
    cyc("post_rst_fetch", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk_ret("post_rst_retired");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
